// File: rtl/lab_pkg.sv
// lab_pkg -- definitions shared by the fetch stage and the decode stage.
//   MEM_DERINLIK_VARSAYILAN : default instruction-memory depth (32-bit words)
//   DATA_W                  : instruction word width
//   durum_t                 : fetch FSM states BOSTA / GETIR / HATA
//   OP_R/OP_I/OP_U/OP_B     : opcode field values decoded downstream
//   hizali()                : true when a byte address is word aligned
package lab_pkg;

   localparam int MEM_DERINLIK_VARSAYILAN = 32;
   localparam int DATA_W                  = 32;

   typedef enum logic [1:0] {
      BOSTA = 2'd0,
      GETIR = 2'd1,
      HATA  = 2'd2
   } durum_t;

   localparam logic [6:0] OP_R = 7'b0000001;
   localparam logic [6:0] OP_I = 7'b0000011;
   localparam logic [6:0] OP_U = 7'b0000111;
   localparam logic [6:0] OP_B = 7'b0001111;

   function automatic logic hizali(input logic [31:0] adres);
      return (adres[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/komut_bellegi.sv
// komut_bellegi -- instruction memory, one write port and one synchronous
// read port with a read enable so the read register can hold a word while
// the fetch stage is stalled.
//   clk       : clock
//   reset     : synchronous active-low; clears only the read register
//   yaz_en    : write enable
//   yaz_adres : write word index
//   yaz_veri  : write data
//   oku_en    : read enable (read register updates only when set)
//   oku_adres : read word index
//   okunan    : registered read data, one cycle after oku_en
module komut_bellegi
#(
   parameter int MEM_DERINLIK = 32,
   parameter int DATA_W       = 32
)(
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            yaz_en,
   input  logic [$clog2(MEM_DERINLIK)-1:0] yaz_adres,
   input  logic [DATA_W-1:0]               yaz_veri,
   input  logic                            oku_en,
   input  logic [$clog2(MEM_DERINLIK)-1:0] oku_adres,
   output logic [DATA_W-1:0]               okunan
);

   logic [DATA_W-1:0] mem [MEM_DERINLIK];
   logic [DATA_W-1:0] okunan_p1;

   // Array contents survive reset; a program can be loaded while in reset.
   always_ff @(posedge clk) begin
      if (yaz_en)
         mem[yaz_adres] <= yaz_veri;
   end

   // ---- read stage: a same-cycle write to the read word yields old data ----
   always_ff @(posedge clk) begin
      if (!reset)
         okunan_p1 <= '0;
      else if (oku_en)
         okunan_p1 <= mem[oku_adres];
   end

   assign okunan = okunan_p1;

endmodule

// File: rtl/komut_getir.sv
// komut_getir -- instruction fetch stage: PC, fetch FSM and handshake to
// the decode stage, with the instruction memory in komut_bellegi.
//   clk          : clock
//   reset        : synchronous active-low reset
//   prog_we      : program-load write enable
//   prog_addr    : program-load word index
//   prog_data    : program-load instruction word
//   dallan       : redirect request (taken branch)
//   dallan_adres : redirect byte address
//   komut_ready  : decode stage accepts komut this cycle
//   komut        : fetched instruction word
//   pc_out       : byte address of komut
//   komut_valid  : komut / pc_out valid
//   hata         : sticky misaligned-redirect error
module komut_getir
   import lab_pkg::*;
#(
   parameter int MEM_DERINLIK = MEM_DERINLIK_VARSAYILAN
)(
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            prog_we,
   input  logic [$clog2(MEM_DERINLIK)-1:0] prog_addr,
   input  logic [31:0]                     prog_data,
   input  logic                            dallan,
   input  logic [31:0]                     dallan_adres,
   input  logic                            komut_ready,
   output logic [31:0]                     komut,
   output logic [31:0]                     pc_out,
   output logic                            komut_valid,
   output logic                            hata
);

   localparam int AW = $clog2(MEM_DERINLIK);

   durum_t      durum;
   logic [31:0] pc_p0;      // address of the next word to read
   logic [31:0] pc_p1;      // address of the word in the read register
   logic        vld_p1;
   logic        hata_q;

   logic        yonlendir;
   logic        hizasiz;
   logic        ilerle;

   // The memory read register doubles as the output holding register, so a
   // stall just withholds the read enable; no separate skid entry is needed.
   // A redirect suppresses the read for one cycle, which is what produces
   // the single invalid cycle before the target word appears.
   always_comb begin
      yonlendir = 1'b0;
      hizasiz   = 1'b0;
      ilerle    = 1'b0;
      if (durum == GETIR) begin
         yonlendir = dallan &&  hizali(dallan_adres);
         hizasiz   = dallan && !hizali(dallan_adres);
         ilerle    = !dallan && (!vld_p1 || komut_ready);
      end
   end

   // ---- p0 -> p1: issue the read of pc_p0 into the memory read register ----
   komut_bellegi #(
      .MEM_DERINLIK (MEM_DERINLIK),
      .DATA_W       (DATA_W)
   ) u_bellek (
      .clk       (clk),
      .reset     (reset),
      .yaz_en    (prog_we),
      .yaz_adres (prog_addr),
      .yaz_veri  (prog_data),
      .oku_en    (ilerle),
      .oku_adres (pc_p0[AW+1:2]),
      .okunan    (komut)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         durum  <= BOSTA;
         pc_p0  <= '0;
         pc_p1  <= '0;
         vld_p1 <= 1'b0;
         hata_q <= 1'b0;
      end else begin
         case (durum)
            BOSTA: durum <= GETIR;
            GETIR: begin
               if (hizasiz) begin
                  durum  <= HATA;
                  hata_q <= 1'b1;
                  vld_p1 <= 1'b0;
               end else if (yonlendir) begin
                  pc_p0  <= dallan_adres;
                  vld_p1 <= 1'b0;
               end else if (ilerle) begin
                  pc_p1  <= pc_p0;
                  pc_p0  <= pc_p0 + 32'd4;
                  vld_p1 <= 1'b1;
               end
            end
            HATA: begin
               // Only reset leaves the error state.
            end
            default: durum <= BOSTA;
         endcase
      end
   end

   assign pc_out      = pc_p1;
   assign komut_valid = vld_p1;
   assign hata        = hata_q;

endmodule

// File: tb/tb_komut_getir.sv
// tb_komut_getir -- self-checking bench for komut_getir: directed scenarios
// plus randomized stall/redirect traffic against an in-order stream model.
module tb_komut_getir;

   localparam int MEM_D = 32;

   logic        clk = 1'b0;
   logic        reset;
   logic        prog_we;
   logic [4:0]  prog_addr;
   logic [31:0] prog_data;
   logic        dallan;
   logic [31:0] dallan_adres;
   logic        komut_ready;
   logic [31:0] komut;
   logic [31:0] pc_out;
   logic        komut_valid;
   logic        hata;

   logic [31:0] tb_mem [MEM_D];
   int tests = 0;
   int fails = 0;

   komut_getir #(.MEM_DERINLIK(MEM_D)) dut (
      .clk          (clk),
      .reset        (reset),
      .prog_we      (prog_we),
      .prog_addr    (prog_addr),
      .prog_data    (prog_data),
      .dallan       (dallan),
      .dallan_adres (dallan_adres),
      .komut_ready  (komut_ready),
      .komut        (komut),
      .pc_out       (pc_out),
      .komut_valid  (komut_valid),
      .hata         (hata)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] ref_word(input logic [31:0] adres);
      return tb_mem[(adres >> 2) % MEM_D];
   endfunction

   task automatic load_word(input int idx, input logic [31:0] data);
      prog_we   = 1'b1;
      prog_addr = idx[4:0];
      prog_data = data;
      tick();
      prog_we   = 1'b0;
      tb_mem[idx] = data;
   endtask

   task automatic test_reset();
      reset = 1'b0; dallan = 1'b1; dallan_adres = 32'h40; komut_ready = 1'b1;
      prog_we = 1'b0; prog_addr = '0; prog_data = '0;
      tick();
      for (int i = 0; i < MEM_D; i++) load_word(i, $urandom);
      load_word(0, 32'h40A31981);
      load_word(1, 32'h40A31983);
      load_word(2, 32'h40A31987);
      load_word(3, 32'h40A3198F);
      dallan = 1'b0;
      tests++;
      if (komut_valid !== 1'b0 || hata !== 1'b0 || pc_out !== 32'h0 || komut !== 32'h0) begin
         fails++;
         $display("FAIL reset_state: valid=%b hata=%b pc_out=%h komut=%h, expected 0 0 0 0",
                  komut_valid, hata, pc_out, komut);
      end
   endtask

   task automatic test_startup();
      komut_ready = 1'b1;
      reset = 1'b1;
      tick();
      tests++;
      if (komut_valid !== 1'b0) begin
         fails++;
         $display("FAIL startup_cycle1: valid=%b, expected 0", komut_valid);
      end
      tick();
      for (int i = 0; i < 4; i++) begin
         tests++;
         if (komut_valid !== 1'b1 || pc_out !== 32'(4 * i) || komut !== tb_mem[i]) begin
            fails++;
            $display("FAIL startup_seq%0d: valid=%b pc_out=%h komut=%h, expected 1 %h %h",
                     i, komut_valid, pc_out, komut, 32'(4 * i), tb_mem[i]);
         end
         tick();
      end
   endtask

   task automatic test_stall();
      reset = 1'b0; komut_ready = 1'b1; tick();
      reset = 1'b1; tick(); tick(); tick();
      komut_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         tests++;
         if (komut_valid !== 1'b1 || pc_out !== 32'h4 || komut !== tb_mem[1]) begin
            fails++;
            $display("FAIL stall_hold%0d: valid=%b pc_out=%h komut=%h, expected 1 00000004 %h",
                     i, komut_valid, pc_out, komut, tb_mem[1]);
         end
      end
      komut_ready = 1'b1;
      for (int i = 2; i < 4; i++) begin
         tick();
         tests++;
         if (komut_valid !== 1'b1 || pc_out !== 32'(4 * i) || komut !== tb_mem[i]) begin
            fails++;
            $display("FAIL stall_resume%0d: valid=%b pc_out=%h komut=%h, expected 1 %h %h",
                     i, komut_valid, pc_out, komut, 32'(4 * i), tb_mem[i]);
         end
      end
   endtask

   task automatic test_redirect_stall();
      komut_ready = 1'b0;
      tick();
      dallan = 1'b1; dallan_adres = 32'h10;
      tick();
      dallan = 1'b0;
      tests++;
      if (komut_valid !== 1'b0) begin
         fails++;
         $display("FAIL redirect_bubble: valid=%b, expected 0", komut_valid);
      end
      tick();
      tests++;
      if (komut_valid !== 1'b1 || pc_out !== 32'h10 || komut !== tb_mem[4]) begin
         fails++;
         $display("FAIL redirect_target: valid=%b pc_out=%h komut=%h, expected 1 00000010 %h",
                  komut_valid, pc_out, komut, tb_mem[4]);
      end
   endtask

   task automatic test_misaligned();
      dallan = 1'b1; dallan_adres = 32'h12;
      tick();
      tests++;
      if (hata !== 1'b1 || komut_valid !== 1'b0) begin
         fails++;
         $display("FAIL misaligned_set: hata=%b valid=%b, expected 1 0", hata, komut_valid);
      end
      dallan_adres = 32'h20;
      for (int i = 0; i < 4; i++) begin
         dallan = i[0];
         komut_ready = $urandom_range(0, 1) != 0;
         tick();
         tests++;
         if (hata !== 1'b1 || komut_valid !== 1'b0) begin
            fails++;
            $display("FAIL misaligned_hold%0d: hata=%b valid=%b, expected 1 0", i, hata, komut_valid);
         end
      end
      dallan = 1'b0; reset = 1'b0;
      tick();
      tests++;
      if (hata !== 1'b0 || komut_valid !== 1'b0 || pc_out !== 32'h0 || komut !== 32'h0) begin
         fails++;
         $display("FAIL misaligned_clear: hata=%b valid=%b pc_out=%h komut=%h, expected 0 0 0 0",
                  hata, komut_valid, pc_out, komut);
      end
      reset = 1'b1; komut_ready = 1'b1;
      tick(); tick();
      tests++;
      if (komut_valid !== 1'b1 || pc_out !== 32'h0 || komut !== tb_mem[0]) begin
         fails++;
         $display("FAIL misaligned_restart: valid=%b pc_out=%h komut=%h, expected 1 00000000 %h",
                  komut_valid, pc_out, komut, tb_mem[0]);
      end
   endtask

   task automatic test_wrap_and_reset_dallan();
      komut_ready = 1'b1;
      for (int i = 1; i <= MEM_D; i++) begin
         tick();
         tests++;
         if (komut_valid !== 1'b1 || pc_out !== 32'(4 * i) || komut !== tb_mem[i % MEM_D]) begin
            fails++;
            $display("FAIL wrap_seq%0d: valid=%b pc_out=%h komut=%h, expected 1 %h %h",
                     i, komut_valid, pc_out, komut, 32'(4 * i), tb_mem[i % MEM_D]);
         end
      end
      reset = 1'b0; dallan = 1'b1; dallan_adres = 32'h40; komut_ready = 1'b0;
      tick();
      tests++;
      if (komut_valid !== 1'b0 || pc_out !== 32'h0 || komut !== 32'h0 || hata !== 1'b0) begin
         fails++;
         $display("FAIL reset_over_dallan: valid=%b pc_out=%h komut=%h hata=%b, expected 0 0 0 0",
                  komut_valid, pc_out, komut, hata);
      end
      reset = 1'b1; dallan = 1'b0;
      tick(); tick();
      tests++;
      if (komut_valid !== 1'b1 || pc_out !== 32'h0 || komut !== tb_mem[0]) begin
         fails++;
         $display("FAIL reset_over_dallan_restart: valid=%b pc_out=%h komut=%h, expected 1 00000000 %h",
                  komut_valid, pc_out, komut, tb_mem[0]);
      end
   endtask

   task automatic test_prog_write();
      logic [31:0] eski, yeni;
      eski = tb_mem[0];
      yeni = ~eski;
      reset = 1'b0; komut_ready = 1'b1; tick();
      reset = 1'b1; tick();
      prog_we = 1'b1; prog_addr = 5'd0; prog_data = yeni;
      tick();
      prog_we = 1'b0;
      tb_mem[0] = yeni;
      tests++;
      if (komut_valid !== 1'b1 || pc_out !== 32'h0 || komut !== eski) begin
         fails++;
         $display("FAIL write_read_old: valid=%b pc_out=%h komut=%h, expected 1 00000000 %h",
                  komut_valid, pc_out, komut, eski);
      end
      dallan = 1'b1; dallan_adres = 32'h0;
      tick();
      dallan = 1'b0;
      tick();
      tests++;
      if (komut_valid !== 1'b1 || pc_out !== 32'h0 || komut !== yeni) begin
         fails++;
         $display("FAIL write_read_new: valid=%b pc_out=%h komut=%h, expected 1 00000000 %h",
                  komut_valid, pc_out, komut, yeni);
      end
   endtask

   task automatic test_random_traffic(input int n);
      logic [31:0] exp_pc, prev_pc, prev_k, tgt;
      logic        prev_v, rdy, br;
      reset = 1'b0; dallan = 1'b0; komut_ready = 1'b0; tick();
      reset = 1'b1; tick(); tick();
      exp_pc = 32'h0;
      for (int c = 0; c < n; c++) begin
         if (komut_valid === 1'b1) begin
            tests++;
            if (pc_out !== exp_pc || komut !== ref_word(exp_pc)) begin
               fails++;
               $display("FAIL rand_order c%0d: pc_out=%h komut=%h, expected %h %h",
                        c, pc_out, komut, exp_pc, ref_word(exp_pc));
            end
         end
         prev_v  = komut_valid;
         prev_pc = pc_out;
         prev_k  = komut;
         rdy = $urandom_range(0, 2) != 0;
         br  = $urandom_range(0, 11) == 0;
         if ($urandom_range(0, 5) == 0)
            tgt = 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3));
         else
            tgt = 32'(4 * $urandom_range(0, 255));
         komut_ready = rdy; dallan = br; dallan_adres = tgt;
         tick();
         tests++;
         if (br) begin
            exp_pc = tgt;
            if (komut_valid !== 1'b0) begin
               fails++;
               $display("FAIL rand_bubble c%0d: valid=%b, expected 0", c, komut_valid);
            end
         end else if (prev_v && !rdy) begin
            if (komut_valid !== 1'b1 || pc_out !== prev_pc || komut !== prev_k) begin
               fails++;
               $display("FAIL rand_hold c%0d: valid=%b pc_out=%h komut=%h, expected 1 %h %h",
                        c, komut_valid, pc_out, komut, prev_pc, prev_k);
            end
         end else begin
            if (prev_v) exp_pc = exp_pc + 32'd4;
            if (komut_valid !== 1'b1) begin
               fails++;
               $display("FAIL rand_throughput c%0d: valid=%b, expected 1", c, komut_valid);
            end
         end
      end
      dallan = 1'b0;
   endtask

   initial begin
      test_reset();
      test_startup();
      test_stall();
      test_redirect_stall();
      test_misaligned();
      test_wrap_and_reset_dallan();
      test_prog_write();
      test_random_traffic(2000);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
